// File: rtl/multiplier_seq.sv
// ---------------------------------------------------------------------------
// multiplier_seq
//
// Iterative signed WIDTH x WIDTH -> 2*WIDTH multiplier for the ray/scene math
// path. It rescales fixed-point values after the divider, so its product has
// the same width and format as the divider's quotient.
//
// How it works: radix-2 shift-add on the operand magnitudes, then a two's
// complement sign fix-up. Requests use a start/busy/done handshake.
//
// Ports
//   CLK      in   1          clock, all state changes on the rising edge
//   RESET    in   1          asynchronous active-high reset, aborts any
//                            operation in flight
//   start    in   1          request, only looked at while idle
//   a        in   WIDTH      signed multiplicand, captured when start is accepted
//   b        in   WIDTH      signed multiplier, captured when start is accepted
//   busy     out  1          high whenever the unit is not idle
//   done     out  1          one-cycle pulse, product is valid from this cycle
//   product  out  2*WIDTH    signed a*b, held until the next accepted start
//
// Every output comes straight from a register, so there is no combinational
// path from start, a or b to any output.
// ---------------------------------------------------------------------------
module multiplier_seq #(
  parameter int WIDTH = 64
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [2*WIDTH-1:0]    acc_q;
  logic [2*WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]      mplier_q;
  logic                  sign_q;
  logic [CW-1:0]         count_q;

  logic [WIDTH-1:0]      aMag;
  logic [WIDTH-1:0]      bMag;
  logic [2*WIDTH-1:0]    accSum_d;

  // Treat the magnitudes as unsigned WIDTH-bit values. Negating the most
  // negative input then yields 2^(WIDTH-1), which is exactly right when read
  // as unsigned.
  // The multiplicand is kept pre-shifted in a 2*WIDTH register and moves
  // left one bit per step. This replaces a variable shift by count.
  always_comb begin
    aMag     = a[WIDTH-1] ? -a : a;
    bMag     = b[WIDTH-1] ? -b : b;
    accSum_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Control FSM with registered busy/done/product.
  // busy is high through RUN, FIX and DONE. A start seen in any of those
  // states is dropped, not queued.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      count_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, aMag};
            mplier_q <= bMag;
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_q    <= '0;
            count_q  <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= accSum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // A zero magnitude negates to zero, so there is no negative zero.
          product <= sign_q ? -acc_q : acc_q;
          done    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_multiplier_seq
//
// Directed testbench for multiplier_seq at WIDTH = 64.
// Expected products are written out by hand. The random back-to-back phase
// compares against a sign-extended 128-bit reference multiply.
// ---------------------------------------------------------------------------
module tb_multiplier_seq;

  localparam int W = 64;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           start;
  logic [W-1:0]   aIn;
  logic [W-1:0]   bIn;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int testsRun    = 0;
  int testsFailed = 0;

  multiplier_seq #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .a       (aIn),
    .b       (bIn),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock with a 10-unit period.
  always #5 CLK = ~CLK;

  // Single comparison point. It counts each check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Waits for done, sampling 1 unit after each rising edge.
  // lat is the number of edges waited. The wait is bounded so the bench
  // cannot hang.
  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < W + 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  // Issues one operation from idle and checks its latency and product.
  // The operands are scrambled right after acceptance, which shows that
  // they were captured on the accepted edge. The task returns once the unit
  // is idle again, so consecutive calls run back-to-back.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [2*W-1:0] exp, input string tag);
    int lat;
    @(negedge CLK);
    aIn   = av;
    bIn   = bv;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    aIn   = ~av;
    bIn   = bv + 64'd1;
    waitDone(lat);
    checkOutput({tag, "_lat"}, 128'(lat), 128'(W + 1));
    checkOutput(tag, product, exp);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int busyCnt;
    int doneCnt;
    int doneAt;
    int lat;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] refProd;

    RESET = 1'b1;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    #12;
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    checkOutput("rst_product", product, 128'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Test 1: 3*5 with a one-cycle start.
    // busy spans RUN (W cycles) plus FIX and DONE.
    // done appears W+1 edges after the accepting edge.
    @(negedge CLK);
    aIn   = 64'd3;
    bIn   = 64'd5;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    for (int i = 0; i < W + 8; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
      end
      @(posedge CLK);
      #1;
    end
    checkOutput("t1_busy_cycles", 128'(busyCnt), 128'(W + 2));
    checkOutput("t1_done_count", 128'(doneCnt), 128'd1);
    checkOutput("t1_done_at", 128'(doneAt), 128'(W + 1));
    checkOutput("t1_product", product, 128'd15);

    // Test 2: mixed signs.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd6,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFD6, "t2_m7x6");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFA,
                  128'd42, "t2_m7xm6");

    // Test 3: extremes.
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  128'h40000000_00000000_00000000_00000000, "t3_minxmin");
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'h00000000_00000000_80000000_00000000, "t3_minxm1");
    applyStimulus(64'd0, 64'h8000_0000_0000_0000, 128'd0, "t3_zeroxmin");
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  128'h3FFFFFFF_FFFFFFFF_00000000_00000001, "t3_maxxmax");

    // Test 4a: a start pulse mid-operation is dropped and not queued.
    @(negedge CLK);
    aIn   = 64'd11;
    bIn   = 64'hFFFF_FFFF_FFFF_FFFD;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    aIn   = 64'd100;
    bIn   = 64'd100;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("t4_ignored_product", product, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFDF);
    @(posedge CLK);
    #1;
    checkOutput("t4_not_queued0", 128'(busy), 128'd0);
    @(posedge CLK);
    #1;
    checkOutput("t4_not_queued1", 128'(busy), 128'd0);

    // Test 4b: start held high across DONE.
    // It is taken only on the following IDLE cycle.
    @(negedge CLK);
    aIn   = 64'hFFFF_FFFF_FFFF_FFF9;
    bIn   = 64'hFFFF_FFFF_FFFF_FFFA;
    start = 1'b1;
    @(posedge CLK);
    #1;
    aIn = 64'd9;
    bIn = 64'hFFFF_FFFF_FFFF_FFFC;
    waitDone(lat);
    checkOutput("t4_held_lat", 128'(lat), 128'(W + 1));
    checkOutput("t4_held_product1", product, 128'd42);
    checkOutput("t4_held_busy_done", 128'(busy), 128'd1);
    @(posedge CLK);
    #1;
    checkOutput("t4_held_idle", 128'(busy), 128'd0);
    @(posedge CLK);
    #1;
    checkOutput("t4_held_accept", 128'(busy), 128'd1);
    start = 1'b0;
    waitDone(lat);
    checkOutput("t4_held_product2", product, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFDC);
    @(posedge CLK);
    #1;

    // Test 5: reset during RUN aborts the operation without a done.
    @(negedge CLK);
    aIn   = 64'd5;
    bIn   = 64'd7;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("t5_busy", 128'(busy), 128'd0);
    checkOutput("t5_done", 128'(done), 128'd0);
    checkOutput("t5_product", product, 128'd0);
    @(negedge CLK);
    RESET   = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge CLK);
      #1;
      if (done) doneCnt++;
    end
    checkOutput("t5_abort_no_done", 128'(doneCnt), 128'd0);
    applyStimulus(64'd5, 64'd7, 128'd35, "t5_after_reset");

    // Test 6: random signed pairs issued back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra      = {$urandom(), $urandom()};
      rb      = {$urandom(), $urandom()};
      refProd = {{W{ra[W-1]}}, ra} * {{W{rb[W-1]}}, rb};
      applyStimulus(ra, rb, refProd, "t6_random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
